// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers with per-channel tick strobes,
// a power-on lock delay and period-boundary (glitch-free) reconfiguration.
module clock_divider_bank #(
   parameter int NUM_CHANNEL = 3,
   parameter int DIV_WIDTH   = 8,
   parameter int LOCK_CYCLES = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int DEFAULT_EN  = 1,
   localparam int CW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CW-1:0]          cfg_channel,
   input  logic [DIV_WIDTH-1:0]   cfg_div,
   input  logic                   cfg_enable,
   output logic [NUM_CHANNEL-1:0] clk_div,
   output logic [NUM_CHANNEL-1:0] tick,
   output logic                   locked
);

   localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [LCW-1:0]   lock_cnt_reg;
   logic             locked_reg;
   logic [2**CW-1:0] pending_ext;
   logic             accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_cnt_reg <= '0;
         locked_reg   <= 1'b0;
      end else if (!locked_reg) begin
         if (lock_cnt_reg == LCW'(LOCK_CYCLES - 1))
            locked_reg <= 1'b1;
         else
            lock_cnt_reg <= lock_cnt_reg + 1'b1;
      end
   end

   assign locked = locked_reg;

   // Out-of-range channel indices see a zero pending bit, so they are accepted and dropped.
   generate
      if (2**CW > NUM_CHANNEL) begin : g_pad
         assign pending_ext[2**CW-1:NUM_CHANNEL] = '0;
      end
   endgenerate

   assign cfg_ready = locked_reg & ~pending_ext[cfg_channel];
   assign accept    = cfg_valid & cfg_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHANNEL; gi++) begin : g_ch
         logic [DIV_WIDTH-1:0] cnt_reg;
         logic [DIV_WIDTH-1:0] div_reg;
         logic [DIV_WIDTH-1:0] sh_div_reg;
         logic                 en_reg;
         logic                 sh_en_reg;
         logic                 pend_reg;
         logic                 clk_reg;
         logic                 tick_reg;
         logic                 last;
         logic                 apply;
         logic                 hit;

         // N of 0 or 1 collapses to a single-state period: every cycle is a boundary.
         assign last  = (div_reg <= DIV_WIDTH'(1)) || (cnt_reg == div_reg - DIV_WIDTH'(1));
         assign apply = pend_reg & (~en_reg | last);
         assign hit   = accept && (cfg_channel == CW'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg    <= '0;
               div_reg    <= DIV_WIDTH'(DEFAULT_DIV);
               en_reg     <= (DEFAULT_EN != 0);
               sh_div_reg <= '0;
               sh_en_reg  <= 1'b0;
               pend_reg   <= 1'b0;
               clk_reg    <= 1'b0;
               tick_reg   <= 1'b0;
            end else begin
               if (locked_reg) begin
                  if (en_reg) begin
                     clk_reg  <= (cnt_reg < (div_reg >> 1));
                     tick_reg <= (cnt_reg == '0);
                     cnt_reg  <= last ? '0 : cnt_reg + 1'b1;
                  end else begin
                     clk_reg  <= 1'b0;
                     tick_reg <= 1'b0;
                     cnt_reg  <= '0;
                  end
                  if (apply) begin
                     cnt_reg  <= '0;
                     div_reg  <= sh_div_reg;
                     en_reg   <= sh_en_reg;
                     pend_reg <= 1'b0;
                  end
               end
               if (hit) begin
                  pend_reg   <= 1'b1;
                  sh_div_reg <= cfg_div;
                  sh_en_reg  <= cfg_enable;
               end
            end
         end

         assign clk_div[gi]     = clk_reg;
         assign tick[gi]        = tick_reg;
         assign pending_ext[gi] = pend_reg;
      end
   endgenerate

endmodule
